coin_acceptor: RTL and testbench

- Front-end coin mechanism interface that drives the N/D coin inputs of the vending machine FSM.
- Synchronises and debounces raw nickel/dime sensor levels and detects coin insertions.
- Queues detected coins in a small FIFO, then replays each as a single-cycle N or D pulse with a guaranteed idle gap.
- Refuses coins while the vending machine signals inhibit (door open) and flags rejects and overflow.

---
 rtl/coin_acceptor.sv | 142 ++++++++++++++
 tb/tb_coin_acceptor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin mechanism front end: synchronises and debounces the nickel/dime sensors,
// queues accepted coins and replays them as single-cycle N/D pulses with an idle gap.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               coin_n_in,
    input  logic                               coin_d_in,
    input  logic                               inhibit,
    output logic                               N,
    output logic                               D,
    output logic                               coin_reject,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [CW:0]   DEPTH    = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t          state;
    logic [GW-1:0]   gap_cnt;

    // Bit 0 is the nickel channel, bit 1 the dime channel.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [1:0]      coin_event;
    logic [DW-1:0]   db_cnt [2];

    logic            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            head;
    logic            pop;
    logic            push_n;
    logic            push_d;
    logic            refuse_full;
    logic [CW:0]     free_slots;

    assign raw = {coin_d_in, coin_n_in};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A coin is the edge at which a stable level is about to flip from 0 to 1.
    assign coin_event[0] = sync2[0] && !stable[0] && (db_cnt[0] == DB_LAST);
    assign coin_event[1] = sync2[1] && !stable[1] && (db_cnt[1] == DB_LAST);

    assign head = mem[rd_ptr];
    assign pop  = (fifo_count != '0) && !inhibit &&
                  ((state == IDLE) || ((state == GAP) && (gap_cnt == GAP_LAST)));

    // Space counts the slot freed by a same-edge pop; the nickel claims a slot before the dime.
    always_comb begin
        free_slots  = DEPTH - {1'b0, fifo_count} + {{CW{1'b0}}, pop};
        push_n      = coin_event[0] && !inhibit && (free_slots != '0);
        push_d      = coin_event[1] && !inhibit && (free_slots > {{CW{1'b0}}, push_n});
        refuse_full = !inhibit && ((coin_event[0] && !push_n) || (coin_event[1] && !push_d));
    end

    always_ff @(posedge clk) begin
        if (push_n) mem[wr_ptr] <= 1'b0;
        if (push_d) mem[wr_ptr + PW'(push_n)] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            coin_reject <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(push_n) + PW'(push_d);
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count  <= fifo_count + CW'(push_n) + CW'(push_d) - CW'(pop);
            coin_reject <= (coin_event[0] && !push_n) || (coin_event[1] && !push_d);
            if (refuse_full) overflow <= 1'b1;
        end
    end

    // The last gap cycle may launch the next pulse directly, so exactly GAP_CYCLES idle cycles separate pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            N       <= 1'b0;
            D       <= 1'b0;
        end else begin
            N <= 1'b0;
            D <= 1'b0;
            case (state)
                PULSE: begin
                    state   <= GAP;
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (pop) begin
                state <= PULSE;
                N     <= !head;
                D     <= head;
            end
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a default instance plus a fast-debounce instance used to fill the queue.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_n_in, coin_d_in, inhibit;
    logic       N, D, coin_reject, overflow;
    logic [2:0] fifo_count;

    logic       f_n_in, f_d_in, f_inhibit;
    logic       f_N, f_D, f_reject, f_overflow;
    logic [2:0] f_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int pulse_cyc[$];
    bit pulse_is_d[$];
    int rej_cyc[$];
    int max_count = 0;
    int viol = 0;
    bit prev_pulse = 1'b0;

    int f_pulse_cyc[$];
    bit f_pulse_is_d[$];
    int f_rej_cyc[$];
    int f_max_count = 0;
    int f_viol = 0;
    bit f_prev_pulse = 1'b0;

    always #5 clk = ~clk;

    coin_acceptor dut (
        .clk(clk), .reset(reset), .coin_n_in(coin_n_in), .coin_d_in(coin_d_in),
        .inhibit(inhibit), .N(N), .D(D), .coin_reject(coin_reject),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    coin_acceptor #(.DEBOUNCE_CYCLES(1), .FIFO_DEPTH(4), .GAP_CYCLES(2)) fast (
        .clk(clk), .reset(reset), .coin_n_in(f_n_in), .coin_d_in(f_d_in),
        .inhibit(f_inhibit), .N(f_N), .D(f_D), .coin_reject(f_reject),
        .overflow(f_overflow), .fifo_count(f_count)
    );

    // Advances n rising edges, logging outputs of both instances just after each edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (N || D) begin
                pulse_cyc.push_back(cyc);
                pulse_is_d.push_back(D);
            end
            if ((N && D) || ((N || D) && prev_pulse)) viol++;
            prev_pulse = N || D;
            if (coin_reject) rej_cyc.push_back(cyc);
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (f_N || f_D) begin
                f_pulse_cyc.push_back(cyc);
                f_pulse_is_d.push_back(f_D);
            end
            if ((f_N && f_D) || ((f_N || f_D) && f_prev_pulse)) f_viol++;
            f_prev_pulse = f_N || f_D;
            if (f_reject) f_rej_cyc.push_back(cyc);
            if (int'(f_count) > f_max_count) f_max_count = int'(f_count);
        end
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_is_d.delete();
        rej_cyc.delete();
        f_pulse_cyc.delete();
        f_pulse_is_d.delete();
        f_rej_cyc.delete();
        max_count = 0;
        f_max_count = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        run_cycles(3);
        checks++; if (N !== 1'b0) begin failures++; $display("[TB] FAIL reset_N: got %b expected 0", N); end
        checks++; if (D !== 1'b0) begin failures++; $display("[TB] FAIL reset_D: got %b expected 0", D); end
        checks++; if (coin_reject !== 1'b0) begin failures++; $display("[TB] FAIL reset_reject: got %b expected 0", coin_reject); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (f_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_fast_count: got %0d expected 0", f_count); end
        reset = 1'b1;
        run_cycles(2);
    endtask

    task automatic test_clean_nickel();
        int start, got_c, got_t;
        clear_log();
        start = cyc;
        coin_n_in = 1'b1;
        run_cycles(10);
        coin_n_in = 1'b0;
        run_cycles(15);
        got_c = (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1;
        got_t = (pulse_is_d.size() > 0) ? int'(pulse_is_d[0]) : -1;
        checks++; if (pulse_cyc.size() !== 1) begin failures++; $display("[TB] FAIL clean_pulses: got %0d expected 1", pulse_cyc.size()); end
        checks++; if (got_c !== start + 7) begin failures++; $display("[TB] FAIL clean_time: got %0d expected %0d", got_c, start + 7); end
        checks++; if (got_t !== 0) begin failures++; $display("[TB] FAIL clean_type: got %0d expected 0 (nickel)", got_t); end
        checks++; if (rej_cyc.size() !== 0) begin failures++; $display("[TB] FAIL clean_reject: got %0d expected 0", rej_cyc.size()); end
        checks++; if (max_count !== 1) begin failures++; $display("[TB] FAIL clean_peak: got %0d expected 1", max_count); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL clean_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_bounce();
        int start, got_c, got_t;
        clear_log();
        start = cyc;
        coin_d_in = 1'b1; run_cycles(1);
        coin_d_in = 1'b0; run_cycles(1);
        coin_d_in = 1'b1; run_cycles(1);
        coin_d_in = 1'b0; run_cycles(1);
        coin_d_in = 1'b1; run_cycles(10);
        coin_d_in = 1'b0; run_cycles(15);
        got_c = (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1;
        got_t = (pulse_is_d.size() > 0) ? int'(pulse_is_d[0]) : -1;
        checks++; if (pulse_cyc.size() !== 1) begin failures++; $display("[TB] FAIL bounce_pulses: got %0d expected 1", pulse_cyc.size()); end
        checks++; if (got_c !== start + 11) begin failures++; $display("[TB] FAIL bounce_time: got %0d expected %0d", got_c, start + 11); end
        checks++; if (got_t !== 1) begin failures++; $display("[TB] FAIL bounce_type: got %0d expected 1 (dime)", got_t); end
        checks++; if (rej_cyc.size() !== 0) begin failures++; $display("[TB] FAIL bounce_reject: got %0d expected 0", rej_cyc.size()); end
    endtask

    // Fast instance: three N+D pairs two cycles apart fill the queue, a lone nickel then overflows it.
    task automatic test_burst();
        bit n_pat [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        bit d_pat [8] = '{1, 0, 1, 0, 1, 0, 0, 0};
        int start, got_c, got_t, got_r;
        clear_log();
        start = cyc;
        for (int i = 0; i < 8; i++) begin
            f_n_in = n_pat[i];
            f_d_in = d_pat[i];
            run_cycles(1);
        end
        f_n_in = 1'b0;
        f_d_in = 1'b0;
        run_cycles(20);
        checks++; if (f_pulse_cyc.size() !== 6) begin failures++; $display("[TB] FAIL burst_pulses: got %0d expected 6", f_pulse_cyc.size()); end
        for (int i = 0; i < 6; i++) begin
            got_c = (i < f_pulse_cyc.size()) ? f_pulse_cyc[i] : -1;
            got_t = (i < f_pulse_is_d.size()) ? int'(f_pulse_is_d[i]) : -1;
            checks++; if (got_c !== start + 4 + 3 * i) begin failures++; $display("[TB] FAIL burst_time[%0d]: got %0d expected %0d", i, got_c, start + 4 + 3 * i); end
            checks++; if (got_t !== i % 2) begin failures++; $display("[TB] FAIL burst_type[%0d]: got %0d expected %0d", i, got_t, i % 2); end
        end
        got_r = (f_rej_cyc.size() > 0) ? f_rej_cyc[0] : -1;
        checks++; if (f_rej_cyc.size() !== 1) begin failures++; $display("[TB] FAIL burst_rejects: got %0d expected 1", f_rej_cyc.size()); end
        checks++; if (got_r !== start + 9) begin failures++; $display("[TB] FAIL burst_reject_time: got %0d expected %0d", got_r, start + 9); end
        checks++; if (f_max_count !== 4) begin failures++; $display("[TB] FAIL burst_peak: got %0d expected 4", f_max_count); end
        checks++; if (f_overflow !== 1'b1) begin failures++; $display("[TB] FAIL burst_overflow: got %b expected 1", f_overflow); end
        checks++; if (f_count !== 3'd0) begin failures++; $display("[TB] FAIL burst_count: got %0d expected 0", f_count); end
    endtask

    task automatic test_simultaneous();
        int start, got_c, got_t;
        clear_log();
        start = cyc;
        coin_n_in = 1'b1;
        coin_d_in = 1'b1;
        run_cycles(8);
        coin_n_in = 1'b0;
        coin_d_in = 1'b0;
        run_cycles(15);
        checks++; if (pulse_cyc.size() !== 2) begin failures++; $display("[TB] FAIL simul_pulses: got %0d expected 2", pulse_cyc.size()); end
        for (int i = 0; i < 2; i++) begin
            got_c = (i < pulse_cyc.size()) ? pulse_cyc[i] : -1;
            got_t = (i < pulse_is_d.size()) ? int'(pulse_is_d[i]) : -1;
            checks++; if (got_c !== start + 7 + 3 * i) begin failures++; $display("[TB] FAIL simul_time[%0d]: got %0d expected %0d", i, got_c, start + 7 + 3 * i); end
            checks++; if (got_t !== i) begin failures++; $display("[TB] FAIL simul_type[%0d]: got %0d expected %0d", i, got_t, i); end
        end
        checks++; if (rej_cyc.size() !== 0) begin failures++; $display("[TB] FAIL simul_reject: got %0d expected 0", rej_cyc.size()); end
    endtask

    task automatic test_inhibit();
        int start, rel, got_c, got_t, got_r;
        clear_log();
        start = cyc;
        inhibit = 1'b1;
        coin_n_in = 1'b1;
        run_cycles(8);
        coin_n_in = 1'b0;
        run_cycles(10);
        inhibit = 1'b0;
        got_r = (rej_cyc.size() > 0) ? rej_cyc[0] : -1;
        checks++; if (pulse_cyc.size() !== 0) begin failures++; $display("[TB] FAIL inhibit_pulses: got %0d expected 0", pulse_cyc.size()); end
        checks++; if (rej_cyc.size() !== 1) begin failures++; $display("[TB] FAIL inhibit_rejects: got %0d expected 1", rej_cyc.size()); end
        checks++; if (got_r !== start + 6) begin failures++; $display("[TB] FAIL inhibit_reject_time: got %0d expected %0d", got_r, start + 6); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL inhibit_overflow: got %b expected 0", overflow); end
        checks++; if (max_count !== 0) begin failures++; $display("[TB] FAIL inhibit_queued: got %0d expected 0", max_count); end

        clear_log();
        coin_n_in = 1'b1;
        coin_d_in = 1'b1;
        run_cycles(6);
        inhibit = 1'b1;
        run_cycles(2);
        coin_n_in = 1'b0;
        coin_d_in = 1'b0;
        run_cycles(10);
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("[TB] FAIL hold_count: got %0d expected 2", fifo_count); end
        checks++; if (pulse_cyc.size() !== 0) begin failures++; $display("[TB] FAIL hold_pulses: got %0d expected 0", pulse_cyc.size()); end
        rel = cyc;
        inhibit = 1'b0;
        run_cycles(10);
        checks++; if (pulse_cyc.size() !== 2) begin failures++; $display("[TB] FAIL release_pulses: got %0d expected 2", pulse_cyc.size()); end
        for (int i = 0; i < 2; i++) begin
            got_c = (i < pulse_cyc.size()) ? pulse_cyc[i] : -1;
            got_t = (i < pulse_is_d.size()) ? int'(pulse_is_d[i]) : -1;
            checks++; if (got_c !== rel + 1 + 3 * i) begin failures++; $display("[TB] FAIL release_time[%0d]: got %0d expected %0d", i, got_c, rel + 1 + 3 * i); end
            checks++; if (got_t !== i) begin failures++; $display("[TB] FAIL release_type[%0d]: got %0d expected %0d", i, got_t, i); end
        end
        checks++; if (rej_cyc.size() !== 0) begin failures++; $display("[TB] FAIL release_reject: got %0d expected 0", rej_cyc.size()); end
    endtask

    // Queue two coins behind inhibit, add a third as the first is popped, then reset during the gap.
    task automatic test_reset_mid();
        int start, got_c;
        clear_log();
        start = cyc;
        coin_n_in = 1'b1;
        coin_d_in = 1'b1;
        run_cycles(4);
        coin_n_in = 1'b0;
        coin_d_in = 1'b0;
        run_cycles(2);
        inhibit = 1'b1;
        run_cycles(2);
        coin_n_in = 1'b1;
        run_cycles(4);
        coin_n_in = 1'b0;
        run_cycles(1);
        inhibit = 1'b0;
        run_cycles(2);
        got_c = (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1;
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("[TB] FAIL gap_count: got %0d expected 2", fifo_count); end
        checks++; if (got_c !== start + 14) begin failures++; $display("[TB] FAIL gap_pulse_time: got %0d expected %0d", got_c, start + 14); end
        reset = 1'b0;
        run_cycles(1);
        checks++; if (N !== 1'b0 || D !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ND: got N=%b D=%b expected 0 0", N, D); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL midreset_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL midreset_overflow: got %b expected 0", overflow); end
        checks++; if (f_overflow !== 1'b0) begin failures++; $display("[TB] FAIL midreset_fast_overflow: got %b expected 0", f_overflow); end
        reset = 1'b1;
        run_cycles(20);
        checks++; if (pulse_cyc.size() !== 1) begin failures++; $display("[TB] FAIL postreset_pulses: got %0d expected 1", pulse_cyc.size()); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL postreset_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_invariants();
        checks++; if (viol !== 0) begin failures++; $display("[TB] FAIL invariant_main: got %0d violations expected 0", viol); end
        checks++; if (f_viol !== 0) begin failures++; $display("[TB] FAIL invariant_fast: got %0d violations expected 0", f_viol); end
    endtask

    initial begin
        reset = 1'b0;
        coin_n_in = 1'b0;
        coin_d_in = 1'b0;
        inhibit = 1'b0;
        f_n_in = 1'b0;
        f_d_in = 1'b0;
        f_inhibit = 1'b0;
        $display("[TB] coin_acceptor directed tests");
        test_reset();
        test_clean_nickel();
        test_bounce();
        test_burst();
        test_simultaneous();
        test_inhibit();
        test_reset_mid();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
